// File: rtl/glitch_seq_wb.sv
// Wishbone-configured multi-pulse clock glitcher: delay, N pulses of width W
// separated by gap G, started by register write or a synchronised trigger.
module glitch_seq_wb #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] dat_i,
  input  logic [5:2] adr_i,
  output logic [7:0] dat_o,
  input  logic       stb_i,
  input  logic       we_i,
  output logic       ack_o,
  input  logic       trig_i,
  input  logic       clk_in,
  output logic       clk_out,
  output logic       glitch_o
);

  // state    | meaning
  // S_IDLE   | ready, waiting for start/arm
  // S_ARMED  | waiting for selected trigger edge
  // S_DELAY  | counting D cycles before first pulse
  // S_WIDTH  | pulse applied, glitch_o high for W cycles
  // S_GAP    | G cycles between pulses
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_WIDTH, S_GAP} state_t;

  typedef struct packed {
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [REP_W-1:0] pul;
    logic             gl;
  } step_t;

  logic             r_req, r_req_we;
  logic [3:0]       r_req_adr;
  logic [7:0]       r_req_dat;
  logic             r_ack;
  logic [7:0]       r_dat;

  logic [CNT_W-1:0] r_delay, r_width, r_gap;
  logic [REP_W-1:0] r_count;
  logic [7:0]       r_mode, r_trig_cfg;

  logic [CNT_W-1:0] r_sh_d, r_sh_w, r_sh_g;
  logic [REP_W-1:0] r_sh_n;
  logic [1:0]       r_sh_mode;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [REP_W-1:0] r_pul;
  logic             r_glitch;

  logic             r_trig_s1, r_trig_s2, r_trig_d;

  logic             w_stat_wr, w_abort, w_start, w_arm, w_trig_edge;
  logic [15:0]      w_delay16, w_width16, w_gap16;
  logic [7:0]       w_rd;
  step_t            w_step;
  logic             w_snap;
  logic             w_gate;

  assign w_stat_wr   = r_req & r_req_we & (r_req_adr == 4'd0);
  assign w_abort     = w_stat_wr & r_req_dat[7];
  assign w_start     = w_stat_wr & r_req_dat[0] & ~r_req_dat[7];
  assign w_arm       = w_stat_wr & r_req_dat[1] & ~r_req_dat[0] & ~r_req_dat[7];
  assign w_trig_edge = r_trig_cfg[0] ? (~r_trig_s2 & r_trig_d) : (r_trig_s2 & ~r_trig_d);

  assign w_delay16 = 16'(r_delay);
  assign w_width16 = 16'(r_width);
  assign w_gap16   = 16'(r_gap);

  always_comb begin
    w_rd = 8'h00;
    case (r_req_adr)
      4'd0: w_rd = {6'b0, r_state == S_ARMED, r_state == S_IDLE};
      4'd1: w_rd = w_delay16[7:0];
      4'd2: w_rd = w_delay16[15:8];
      4'd3: w_rd = w_width16[7:0];
      4'd4: w_rd = w_width16[15:8];
      4'd5: w_rd = r_mode;
      4'd6: w_rd = w_gap16[7:0];
      4'd7: w_rd = w_gap16[15:8];
      4'd8: w_rd = 8'(r_count);
      4'd9: w_rd = r_trig_cfg;
      default: w_rd = 8'h00;
    endcase
  end

  // One-cycle request pipeline: strobe at edge k, ack/data/write at edge k+1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req      <= 1'b0;
      r_req_we   <= 1'b0;
      r_req_adr  <= 4'd0;
      r_req_dat  <= 8'h00;
      r_ack      <= 1'b0;
      r_dat      <= 8'h00;
      r_delay    <= '0;
      r_width    <= '0;
      r_gap      <= '0;
      r_count    <= '0;
      r_mode     <= 8'h00;
      r_trig_cfg <= 8'h00;
    end else begin
      r_req     <= stb_i;
      r_req_we  <= we_i;
      r_req_adr <= adr_i;
      r_req_dat <= dat_i;
      r_ack     <= r_req;
      r_dat     <= (r_req & ~r_req_we) ? w_rd : 8'h00;
      if (r_req & r_req_we) begin
        case (r_req_adr)
          4'd1: r_delay[7:0]       <= r_req_dat;
          4'd2: r_delay[CNT_W-1:8] <= r_req_dat[CNT_W-9:0];
          4'd3: r_width[7:0]       <= r_req_dat;
          4'd4: r_width[CNT_W-1:8] <= r_req_dat[CNT_W-9:0];
          4'd5: r_mode             <= r_req_dat;
          4'd6: r_gap[7:0]         <= r_req_dat;
          4'd7: r_gap[CNT_W-1:8]   <= r_req_dat[CNT_W-9:0];
          4'd8: r_count            <= r_req_dat[REP_W-1:0];
          4'd9: r_trig_cfg         <= r_req_dat;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [REP_W-1:0] f_neff(input logic [REP_W-1:0] n);
    return (n == '0) ? REP_W'(1) : n;
  endfunction

  function automatic step_t f_after_pulse(input logic [CNT_W-1:0] w, g,
                                          input logic [REP_W-1:0] n, newp);
    step_t s;
    s.st  = S_IDLE;
    s.cnt = '0;
    s.pul = newp;
    s.gl  = 1'b0;
    if (newp < f_neff(n)) begin
      if (g != '0) begin
        s.st  = S_GAP;
        s.cnt = g;
      end else if (w != '0) begin
        s.st  = S_WIDTH;
        s.cnt = w;
        s.gl  = 1'b1;
      end
    end
    return s;
  endfunction

  // Zero-width pulses are counted without spending a cycle in S_WIDTH.
  function automatic step_t f_enter_width(input logic [CNT_W-1:0] w, g,
                                          input logic [REP_W-1:0] n, pul);
    step_t s;
    if (w != '0) begin
      s.st  = S_WIDTH;
      s.cnt = w;
      s.pul = pul;
      s.gl  = 1'b1;
    end else begin
      s = f_after_pulse(w, g, n, pul + REP_W'(1));
    end
    return s;
  endfunction

  function automatic step_t f_begin(input logic [CNT_W-1:0] d, w, g,
                                    input logic [REP_W-1:0] n);
    step_t s;
    if (d != '0) begin
      s.st  = S_DELAY;
      s.cnt = d;
      s.pul = '0;
      s.gl  = 1'b0;
    end else begin
      s = f_enter_width(w, g, n, '0);
    end
    return s;
  endfunction

  always_comb begin
    w_step.st  = r_state;
    w_step.cnt = r_cnt;
    w_step.pul = r_pul;
    w_step.gl  = r_glitch;
    w_snap     = 1'b0;
    if (w_abort) begin
      w_step.st  = S_IDLE;
      w_step.cnt = '0;
      w_step.gl  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_snap = 1'b1;
            w_step = f_begin(r_delay, r_width, r_gap, r_count);
          end else if (w_arm) begin
            w_snap    = 1'b1;
            w_step.st = S_ARMED;
          end
        end
        S_ARMED: if (w_trig_edge) w_step = f_begin(r_sh_d, r_sh_w, r_sh_g, r_sh_n);
        S_DELAY: begin
          if (r_cnt <= CNT_W'(1)) w_step = f_enter_width(r_sh_w, r_sh_g, r_sh_n, r_pul);
          else w_step.cnt = r_cnt - CNT_W'(1);
        end
        S_WIDTH: begin
          if (r_cnt <= CNT_W'(1))
            w_step = f_after_pulse(r_sh_w, r_sh_g, r_sh_n, r_pul + REP_W'(1));
          else w_step.cnt = r_cnt - CNT_W'(1);
        end
        S_GAP: begin
          if (r_cnt <= CNT_W'(1)) w_step = f_enter_width(r_sh_w, r_sh_g, r_sh_n, r_pul);
          else w_step.cnt = r_cnt - CNT_W'(1);
        end
        default: begin
          w_step.st = S_IDLE;
          w_step.gl = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pul     <= '0;
      r_glitch  <= 1'b0;
      r_sh_d    <= '0;
      r_sh_w    <= '0;
      r_sh_g    <= '0;
      r_sh_n    <= '0;
      r_sh_mode <= 2'b00;
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_trig_d  <= 1'b0;
    end else begin
      r_trig_s1 <= trig_i;
      r_trig_s2 <= r_trig_s1;
      r_trig_d  <= r_trig_s2;
      r_state   <= w_step.st;
      r_cnt     <= w_step.cnt;
      r_pul     <= w_step.pul;
      r_glitch  <= w_step.gl;
      if (w_snap) begin
        r_sh_d    <= r_delay;
        r_sh_w    <= r_width;
        r_sh_g    <= r_gap;
        r_sh_n    <= r_count;
        r_sh_mode <= r_mode[1:0];
      end
    end
  end

  always_comb begin
    case (r_sh_mode)
      2'd0:    w_gate = clk_in;
      2'd1:    w_gate = 1'b0;
      2'd2:    w_gate = 1'b1;
      default: w_gate = ~clk_in;
    endcase
  end

  assign clk_out  = r_glitch ? w_gate : clk_in;
  assign glitch_o = r_glitch;
  assign ack_o    = r_ack;
  assign dat_o    = r_dat;

endmodule

// File: tb/tb_glitch_seq_wb.sv
// Directed bench for glitch_seq_wb: register map, immediate and triggered
// runs, abort, gate modes, shadowing and mid-run reset.
module tb_glitch_seq_wb;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] dat_i = 8'h00;
  logic [3:0] adr_i = 4'd0;
  logic       stb_i = 1'b0;
  logic       we_i  = 1'b0;
  logic       trig_i = 1'b0;
  logic       clk_in = 1'b0;
  logic [7:0] dat_o, dat_o12;
  logic       ack_o, ack_o12, clk_out, clk_out12, glitch_o, glitch_o12;

  int total = 0;
  int bad   = 0;

  glitch_seq_wb #(.CNT_W(16), .REP_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .adr_i(adr_i), .dat_o(dat_o),
    .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o), .trig_i(trig_i),
    .clk_in(clk_in), .clk_out(clk_out), .glitch_o(glitch_o));

  glitch_seq_wb #(.CNT_W(12), .REP_W(8)) dut12 (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .adr_i(adr_i), .dat_o(dat_o12),
    .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o12), .trig_i(trig_i),
    .clk_in(clk_in), .clk_out(clk_out12), .glitch_o(glitch_o12));

  // System clock edges fall on even times, target clock edges on odd times.
  always #10 clk_i = ~clk_i;
  initial begin
    #3;
    forever #6 clk_in = ~clk_in;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic f_gate(input logic [1:0] m, input logic c);
    case (m)
      2'd0:    return c;
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return ~c;
    endcase
  endfunction

  // All bus tasks start just after a falling edge and end on a falling edge.
  task automatic wb_read(input logic [3:0] a, output logic [7:0] d,
                         output logic [7:0] d12, output logic ack_ok);
    logic early;
    adr_i = a; we_i = 1'b0; stb_i = 1'b1;
    @(posedge clk_i); #1;
    stb_i = 1'b0;
    early = ack_o;
    @(posedge clk_i);
    @(negedge clk_i);
    d = dat_o; d12 = dat_o12;
    ack_ok = ack_o & ~early;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
    adr_i = a; dat_i = d; we_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i); #1;
    stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic cfg(input logic [15:0] d, w, g, input logic [7:0] n, m);
    wb_write(4'd1, d[7:0]);  wb_write(4'd2, d[15:8]);
    wb_write(4'd3, w[7:0]);  wb_write(4'd4, w[15:8]);
    wb_write(4'd6, g[7:0]);  wb_write(4'd7, g[15:8]);
    wb_write(4'd8, n);       wb_write(4'd5, m);
  endtask

  task automatic do_reset();
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i); rst_i = 1'b0;
  endtask

  task automatic capture(input int n, input logic [1:0] m,
                         output logic [63:0] gv, output int cbad);
    gv = '0; cbad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      gv[i] = glitch_o;
      if (clk_out !== (glitch_o ? f_gate(m, clk_in) : clk_in)) cbad++;
    end
  endtask

  task automatic wait_glitch(input logic lvl, input string nm);
    int k = 0;
    while (glitch_o !== lvl && k < 60) begin
      @(negedge clk_i); k++;
    end
    if (glitch_o !== lvl) begin
      total++; bad++;
      $display("FAIL %s: glitch_o never reached %0b", nm, lvl);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d, d12; logic ak;
    logic [3:0] adrs [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12};
    logic [7:0] exps [10] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    total++;
    if ({ack_o, glitch_o, dat_o} !== 10'h000) begin
      bad++; $display("FAIL reset_outputs: got ack=%0b glitch=%0b dat=%h, want 0 0 00",
                      ack_o, glitch_o, dat_o);
    end
    for (int i = 0; i < 10; i++) begin
      wb_read(adrs[i], d, d12, ak);
      total++;
      if (d !== exps[i] || ak !== 1'b1) begin
        bad++; $display("FAIL reset_read adr=%0d: got %h ack=%0b, want %h ack=1",
                        adrs[i], d, ak, exps[i]);
      end
    end
  endtask

  task automatic test_readback();
    logic [7:0] d, d12; logic ak;
    logic [3:0] adrs [6] = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd5};
    logic [7:0] vals [6] = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h05, 8'hDC};
    wb_write(4'd2, 8'hFF);
    wb_read(4'd2, d, d12, ak);
    total++;
    if (d !== 8'hFF || d12 !== 8'h0F) begin
      bad++; $display("FAIL delay1_width: got %h / %h, want ff / 0f", d, d12);
    end
    for (int i = 0; i < 6; i++) wb_write(adrs[i], vals[i]);
    for (int i = 0; i < 6; i++) begin
      wb_read(adrs[i], d, d12, ak);
      total++;
      if (d !== vals[i] || ak !== 1'b1) begin
        bad++; $display("FAIL readback adr=%0d: got %h, want %h", adrs[i], d, vals[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0; int dbad = 0;
    wb_write(4'd1, 8'h5A);
    adr_i = 4'd1; we_i = 1'b0; stb_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      if (i == 2) stb_i = 1'b0;
      if (ack_o === 1'b1) begin
        acks++;
        if (dat_o !== 8'h5A) dbad++;
      end
    end
    total++;
    if (acks != 3 || dbad != 0) begin
      bad++; $display("FAIL back_to_back: got %0d acks (%0d bad data), want 3 acks", acks, dbad);
    end
  endtask

  task automatic test_immediate();
    logic [7:0] d, d12; logic ak; logic [63:0] gv; int cb;
    do_reset();
    cfg(16'd8, 16'd4, 16'd3, 8'd3, 8'h01);
    wb_write(4'd0, 8'h01);
    wb_read(4'd0, d, d12, ak);
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL run_status_busy: got %h, want 00", d);
    end
    capture(30, 2'd1, gv, cb);
    total++;
    if (gv !== 64'h0078_F1E0) begin
      bad++; $display("FAIL run_pulses: got %h, want 78f1e0", gv);
    end
    total++;
    if (cb != 0) begin
      bad++; $display("FAIL run_clk_out: %0d samples wrong, want 0", cb);
    end
    wb_read(4'd0, d, d12, ak);
    total++;
    if (d !== 8'h01) begin
      bad++; $display("FAIL run_status_done: got %h, want 01", d);
    end
  endtask

  task automatic test_trigger();
    logic [7:0] d, d12; logic ak; logic [63:0] gv; int cb;
    do_reset();
    trig_i = 1'b1;
    cfg(16'd0, 16'd2, 16'd0, 8'd0, 8'h00);
    wb_write(4'd0, 8'h02);
    wb_read(4'd0, d, d12, ak);
    total++;
    if (d !== 8'h02) begin
      bad++; $display("FAIL armed_status: got %h, want 02", d);
    end
    trig_i = 1'b0;
    capture(6, 2'd0, gv, cb);
    wb_read(4'd0, d, d12, ak);
    total++;
    if (gv !== 64'h0 || d !== 8'h02) begin
      bad++; $display("FAIL fall_ignored: got glitch %h status %h, want 0 02", gv, d);
    end
    trig_i = 1'b1;
    capture(8, 2'd0, gv, cb);
    total++;
    if (gv !== 64'hC || cb != 0) begin
      bad++; $display("FAIL trig_pulse: got %h clkerr=%0d, want c clkerr=0", gv, cb);
    end
    wb_read(4'd0, d, d12, ak);
    total++;
    if (d !== 8'h01) begin
      bad++; $display("FAIL trig_done: got %h, want 01", d);
    end
    trig_i = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] d, d12; logic ak; logic [63:0] gv; int cb;
    do_reset();
    cfg(16'd2, 16'd3, 16'd4, 8'd5, 8'h01);
    wb_write(4'd0, 8'h01);
    wait_glitch(1'b1, "abort_first_rise");
    wait_glitch(1'b0, "abort_first_fall");
    wb_write(4'd0, 8'h01);
    capture(12, 2'd1, gv, cb);
    total++;
    if (gv !== 64'h70E) begin
      bad++; $display("FAIL start_in_gap: got %h, want 70e", gv);
    end
    @(negedge clk_i);
    wait_glitch(1'b1, "abort_rise");
    wb_write(4'd0, 8'h81);
    total++;
    if (glitch_o !== 1'b0) begin
      bad++; $display("FAIL abort_glitch: got %0b, want 0", glitch_o);
    end
    capture(30, 2'd1, gv, cb);
    wb_read(4'd0, d, d12, ak);
    total++;
    if (gv !== 64'h0 || d !== 8'h01) begin
      bad++; $display("FAIL abort_after: got glitch %h status %h, want 0 01", gv, d);
    end
  endtask

  task automatic test_modes();
    logic [63:0] gv; int cb;
    logic [1:0] ms [3] = '{2'd0, 2'd2, 2'd3};
    do_reset();
    cfg(16'd2, 16'd4, 16'd0, 8'd1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      wb_write(4'd5, {6'b0, ms[i]});
      wb_write(4'd0, 8'h01);
      capture(10, ms[i], gv, cb);
      total++;
      if (gv !== 64'h1E || cb != 0) begin
        bad++; $display("FAIL mode%0d: got glitch %h clkerr=%0d, want 1e 0", ms[i], gv, cb);
      end
    end
  endtask

  task automatic test_shadow();
    logic [7:0] d, d12; logic ak; logic [63:0] gv; int cb;
    do_reset();
    cfg(16'd6, 16'd4, 16'd2, 8'd2, 8'h01);
    wb_write(4'd0, 8'h01);
    wb_write(4'd3, 8'h01);
    capture(16, 2'd1, gv, cb);
    total++;
    if (gv !== 64'h1E78 || cb != 0) begin
      bad++; $display("FAIL shadow_width: got %h clkerr=%0d, want 1e78 0", gv, cb);
    end
    wb_read(4'd3, d, d12, ak);
    total++;
    if (d !== 8'h01) begin
      bad++; $display("FAIL shadow_visible: got %h, want 01", d);
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] d, d12; logic ak;
    do_reset();
    cfg(16'd1, 16'd8, 16'd0, 8'd1, 8'h02);
    wb_write(4'd0, 8'h01);
    wait_glitch(1'b1, "midrun_rise");
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    total++;
    if (glitch_o !== 1'b0 || clk_out !== clk_in) begin
      bad++; $display("FAIL midrun_reset: got glitch=%0b clk_out=%0b, want 0 %0b",
                      glitch_o, clk_out, clk_in);
    end
    wb_read(4'd0, d, d12, ak);
    total++;
    if (d !== 8'h01) begin
      bad++; $display("FAIL midrun_status: got %h, want 01", d);
    end
    wb_read(4'd3, d, d12, ak);
    total++;
    if (d !== 8'h00) begin
      bad++; $display("FAIL midrun_cfg_clear: got %h, want 00", d);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    test_reset();
    test_readback();
    test_back_to_back();
    test_immediate();
    test_trigger();
    test_abort();
    test_modes();
    test_shadow();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
